// File: rtl/edge_meas_pkg.sv
// Shared types and helpers for the edge-interval measurement block.
// Holds the FSM state encoding and the counter saturation value.
// No ports; imported by edge_interval_meas_msdsl and sat_counter_msdsl.
package edge_meas_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    MEASURE    = 2'd2
  } meas_state_t;

  // All-ones value for a counter of the given width (callers truncate to width).
  function automatic logic [63:0] sat_value(input int unsigned width);
    logic [63:0] one;
    one = 64'd1;
    return (one << width) - one;
  endfunction

endpackage

// File: rtl/sat_counter_msdsl.sv
// Saturating interval counter: load-to-one, increment, clear, at-max flag.
// Latency: count updates on the clock edge after the command; at_max_o is combinational from the count.
// Backpressure: none; commands are applied every cycle.
// Ports: clk, rst (sync, active-high), clr_i, load_one_i, inc_i, cnt_o[WIDTH], at_max_o.
module sat_counter_msdsl
  import edge_meas_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load_one_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             at_max_o
);

  localparam logic [WIDTH-1:0] SAT_VAL = WIDTH'(sat_value(WIDTH));

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  assign at_max_o = (cnt_q == SAT_VAL);
  assign cnt_o    = cnt_q;

  // Load wins over increment; increment holds at the saturation value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_one_i) begin
      cnt_d = WIDTH'(1);
    end else if (inc_i && !at_max_o) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/edge_interval_meas_msdsl.sv
// Measures clk cycles between successive edge pulses and emits each interval as a sample.
// Latency: a capture in cycle t is visible on out_valid/out_interval at cycle t+1.
// Backpressure: one holding register; a capture while it is full and not popped is dropped (dropped pulse).
// Ports: clk, rst (sync, active-high), edge_in, arm, out_ready in;
//        out_valid, out_interval[WIDTH], out_ovf, busy, dropped out.
module edge_interval_meas_msdsl
  import edge_meas_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SINGLE_SHOT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             edge_in,
  input  logic             arm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_interval,
  output logic             out_ovf,
  output logic             busy,
  output logic             dropped
);

  localparam logic [WIDTH-1:0] SAT_VAL = WIDTH'(sat_value(WIDTH));

  meas_state_t      state_q, state_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] interval_q, interval_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             dropped_q, dropped_d;

  logic [WIDTH-1:0] cnt;
  logic             cnt_at_max;
  logic             cnt_clr, cnt_load_one, cnt_inc;
  logic             capture;
  logic [WIDTH-1:0] cap_interval;
  logic             cap_ovf;
  logic             pop;

  sat_counter_msdsl #(.WIDTH(WIDTH)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (cnt_clr),
    .load_one_i (cnt_load_one),
    .inc_i      (cnt_inc),
    .cnt_o      (cnt),
    .at_max_o   (cnt_at_max)
  );

  // FSM: in IDLE an edge coinciding with arm is ignored because the first
  // reference edge is only accepted from WAIT_FIRST.
  always_comb begin
    state_d      = state_q;
    cnt_clr      = 1'b0;
    cnt_load_one = 1'b0;
    cnt_inc      = 1'b0;
    capture      = 1'b0;
    cap_interval = cnt;
    cap_ovf      = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (arm) state_d = WAIT_FIRST;
      end
      WAIT_FIRST: begin
        if (!arm) begin
          state_d = IDLE;
        end else if (edge_in) begin
          cnt_load_one = 1'b1;
          state_d      = MEASURE;
        end
      end
      MEASURE: begin
        if (!arm) begin
          cnt_clr = 1'b1;
          state_d = IDLE;
        end else if (edge_in) begin
          capture = 1'b1;
          if (SINGLE_SHOT != 0) begin
            state_d = IDLE;
          end else begin
            cnt_load_one = 1'b1;
          end
        end else if (cnt_at_max) begin
          // Timeout: no closing edge within the counter range.
          capture      = 1'b1;
          cap_interval = SAT_VAL;
          cap_ovf      = 1'b1;
          state_d      = WAIT_FIRST;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding register: a same-cycle pop frees the slot for the new capture.
  always_comb begin
    pop        = valid_q && out_ready;
    valid_d    = valid_q && !pop;
    interval_d = interval_q;
    ovf_d      = ovf_q;
    dropped_d  = 1'b0;
    if (capture) begin
      if (!valid_q || pop) begin
        valid_d    = 1'b1;
        interval_d = cap_interval;
        ovf_d      = cap_ovf;
      end else begin
        dropped_d = 1'b1;
      end
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      interval_q <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      interval_q <= interval_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      dropped_q  <= dropped_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_interval = interval_q;
  assign out_ovf      = ovf_q;
  assign busy         = busy_q;
  assign dropped      = dropped_q;

endmodule

// File: tb/tb_edge_interval_meas_msdsl.sv
module tb_edge_interval_meas_msdsl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       arm = 1'b0;
  logic       edge_in = 1'b0;
  logic       out_ready = 1'b1;

  logic       out_valid, out_ovf, busy, dropped;
  logic [7:0] out_interval;
  logic       ss_valid, ss_ovf, ss_busy, ss_dropped;
  logic [7:0] ss_interval;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  edge_interval_meas_msdsl #(.WIDTH(8), .SINGLE_SHOT(0)) dut (
    .clk          (clk),
    .rst          (rst),
    .edge_in      (edge_in),
    .arm          (arm),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_interval (out_interval),
    .out_ovf      (out_ovf),
    .busy         (busy),
    .dropped      (dropped)
  );

  edge_interval_meas_msdsl #(.WIDTH(8), .SINGLE_SHOT(1)) dut_ss (
    .clk          (clk),
    .rst          (rst),
    .edge_in      (edge_in),
    .arm          (arm),
    .out_valid    (ss_valid),
    .out_ready    (out_ready),
    .out_interval (ss_interval),
    .out_ovf      (ss_ovf),
    .busy         (ss_busy),
    .dropped      (ss_dropped)
  );

  // One record = inputs held for n cycles, outputs checked after each cycle.
  typedef struct {
    int         n;
    logic       rst, arm, edge_in, rdy;
    logic       v;
    logic [7:0] iv;
    logic       ov, b, d;
  } vec_t;

  vec_t vecs[64];
  int   nv = 0;

  task automatic add(input int n, input logic r, input logic a, input logic e, input logic rd,
                     input logic v, input logic [7:0] iv, input logic ov, input logic b,
                     input logic d);
    vecs[nv] = '{n: n, rst: r, arm: a, edge_in: e, rdy: rd, v: v, iv: iv, ov: ov, b: b, d: d};
    nv++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive inputs between edges, then sample 1 time unit after the active edge.
  task automatic step(input logic r, input logic a, input logic e, input logic rd);
    rst = r; arm = a; edge_in = e; out_ready = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_main(input string tag, input logic v, input logic [7:0] iv,
                          input logic ov, input logic b, input logic d);
    chk({tag, ".valid"},    {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".interval"}, {24'd0, out_interval}, {24'd0, iv});
    chk({tag, ".ovf"},      {31'd0, out_ovf},   {31'd0, ov});
    chk({tag, ".busy"},     {31'd0, busy},      {31'd0, b});
    chk({tag, ".dropped"},  {31'd0, dropped},   {31'd0, d});
  endtask

  task automatic chk_ss(input string tag, input logic v, input logic [7:0] iv, input logic b);
    chk({tag, ".ss_valid"},    {31'd0, ss_valid}, {31'd0, v});
    chk({tag, ".ss_interval"}, {24'd0, ss_interval}, {24'd0, iv});
    chk({tag, ".ss_busy"},     {31'd0, ss_busy},  {31'd0, b});
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        step(vecs[i].rst, vecs[i].arm, vecs[i].edge_in, vecs[i].rdy);
        chk_main($sformatf("v%0d.%0d", i, k), vecs[i].v, vecs[i].iv, vecs[i].ov,
                 vecs[i].b, vecs[i].d);
      end
    end
  endtask

  initial begin
    //   n rst arm edg rdy  v  iv   ov b  d
    // Reset, then basic intervals 5 and 10 (first edge with arm rise ignored).
    add(2, 1, 0, 0, 1,  0,   0, 0, 0, 0);
    add(1, 0, 1, 1, 1,  0,   0, 0, 1, 0);
    add(8, 0, 1, 0, 1,  0,   0, 0, 1, 0);
    add(1, 0, 1, 1, 1,  0,   0, 0, 1, 0);
    add(4, 0, 1, 0, 1,  0,   0, 0, 1, 0);
    add(1, 0, 1, 1, 1,  1,   5, 0, 1, 0);
    add(1, 0, 1, 0, 1,  0,   5, 0, 1, 0);
    add(8, 0, 1, 0, 1,  0,   5, 0, 1, 0);
    add(1, 0, 1, 1, 1,  1,  10, 0, 1, 0);
    add(1, 0, 1, 0, 1,  0,  10, 0, 1, 0);
    // Re-arm, adjacent edges -> interval 1.
    add(1, 0, 0, 0, 1,  0,  10, 0, 0, 0);
    add(1, 0, 1, 0, 1,  0,  10, 0, 1, 0);
    add(1, 0, 1, 1, 1,  0,  10, 0, 1, 0);
    add(1, 0, 1, 1, 1,  1,   1, 0, 1, 0);   // index 13
    // Holding register full: sample 4 held, next capture dropped, then pop.
    add(1, 0, 0, 0, 0,  0, 255, 1, 0, 0);   // index 14
    add(1, 0, 1, 0, 0,  0, 255, 1, 1, 0);
    add(1, 0, 1, 1, 0,  0, 255, 1, 1, 0);
    add(3, 0, 1, 0, 0,  0, 255, 1, 1, 0);
    add(1, 0, 1, 1, 0,  1,   4, 0, 1, 0);
    add(5, 0, 1, 0, 0,  1,   4, 0, 1, 0);
    add(1, 0, 1, 1, 0,  1,   4, 0, 1, 1);
    add(3, 0, 1, 0, 0,  1,   4, 0, 1, 0);
    add(1, 0, 1, 0, 1,  0,   4, 0, 1, 0);
    // Capture of 7 coinciding with pop of held 4.
    add(1, 0, 0, 0, 0,  0,   4, 0, 0, 0);
    add(1, 0, 1, 0, 0,  0,   4, 0, 1, 0);
    add(1, 0, 1, 1, 0,  0,   4, 0, 1, 0);
    add(3, 0, 1, 0, 0,  0,   4, 0, 1, 0);
    add(1, 0, 1, 1, 0,  1,   4, 0, 1, 0);
    add(6, 0, 1, 0, 0,  1,   4, 0, 1, 0);
    add(1, 0, 1, 1, 1,  1,   7, 0, 1, 0);
    add(1, 0, 1, 0, 1,  0,   7, 0, 1, 0);
    // Reset while holding a sample in MEASURE; edge during reset is ignored.
    add(1, 0, 1, 1, 0,  1,   2, 0, 1, 0);
    add(1, 1, 1, 1, 0,  0,   0, 0, 0, 0);
    add(1, 0, 1, 1, 1,  0,   0, 0, 1, 0);
    add(1, 0, 1, 1, 1,  0,   0, 0, 1, 0);
    add(1, 0, 1, 1, 1,  1,   1, 0, 1, 0);

    run_vecs(0, 14);

    // Timeout: 255 edge-free cycles after the adjacent-edge capture.
    for (int k = 0; k < 254; k++) begin
      step(0, 1, 0, 1);
      chk($sformatf("to.wait%0d.valid", k), {31'd0, out_valid}, 32'd0);
    end
    step(0, 1, 0, 1);
    chk_main("to.sample", 1'b1, 8'd255, 1'b1, 1'b1, 1'b0);
    step(0, 1, 1, 1);   // back in WAIT_FIRST: this edge only opens a new interval
    chk_main("to.first", 1'b0, 8'd255, 1'b1, 1'b1, 1'b0);
    step(0, 1, 0, 1);
    chk_main("to.after", 1'b0, 8'd255, 1'b1, 1'b1, 1'b0);

    run_vecs(14, nv);

    // Single-shot instance: edges at 5, 9, 13 give one sample of 4.
    step(0, 0, 0, 1);
    chk_ss("ss.idle", 1'b0, ss_interval, 1'b0);
    step(0, 1, 0, 1);
    chk_ss("ss.arm", 1'b0, ss_interval, 1'b1);
    step(0, 1, 1, 1);
    chk_ss("ss.e5", 1'b0, ss_interval, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 1);
      chk_ss($sformatf("ss.gap%0d", k), 1'b0, ss_interval, 1'b1);
    end
    step(0, 1, 1, 1);
    chk_ss("ss.e9", 1'b1, 8'd4, 1'b0);
    step(0, 1, 0, 1);
    chk_ss("ss.rearm", 1'b0, 8'd4, 1'b1);
    step(0, 1, 0, 1);
    chk_ss("ss.wait", 1'b0, 8'd4, 1'b1);
    step(0, 1, 1, 1);
    chk_ss("ss.e13", 1'b0, 8'd4, 1'b1);
    step(0, 0, 0, 1);
    chk_ss("ss.disarm", 1'b0, 8'd4, 1'b0);
    step(0, 0, 0, 1);
    chk_ss("ss.idle2", 1'b0, 8'd4, 1'b0);
    chk("ss.dropped", {31'd0, ss_dropped}, 32'd0);
    chk("ss.ovf", {31'd0, ss_ovf}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
